// File: rtl/uart_pkg.sv
// Shared UART definitions: 8N1 frame constants, receiver FSM encoding and
// the bit-period rounding helper used by both uart_tx and uart_rx.
package uart_pkg;

  // 8N1 frame shape
  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned STOP_BITS = 1;

  // Receiver FSM encoding
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } rx_state_e;

  // Clock cycles per bit, rounded to nearest so TX and RX agree exactly
  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baudrate);
    return (clk_freq + (baudrate / 32'd2)) / baudrate;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous input pins. The reset
// value is a parameter so idle-high lines do not glitch low out of reset.
module sync_2ff #(
  parameter int unsigned        p_WIDTH     = 1,
  parameter logic [p_WIDTH-1:0] p_RESET_VAL = {p_WIDTH{1'b1}}
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [p_WIDTH-1:0] d,
  output logic [p_WIDTH-1:0] q
);

  logic [p_WIDTH-1:0] meta_r;
  logic [p_WIDTH-1:0] sync_r;

  // Two-stage capture of the asynchronous input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= p_RESET_VAL;
      sync_r <= p_RESET_VAL;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first, idle-high line. Validates the start bit at
// mid-bit, then samples every data bit and the stop bit at its centre.
// Good frames update o8_rxdata with a one-cycle o_valid; a low stop bit gives
// one o_frame_err pulse and the receiver waits for the line to return high.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned p_BAUDRATE = 9600,
  parameter int unsigned p_CLK_FREQ = 12_000_000
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_uart_rx,
  output logic [7:0] o8_rxdata,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(p_CLK_FREQ, p_BAUDRATE);
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 32'd2;
  localparam int unsigned CNT_W        = (CLKS_PER_BIT > 32'd1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(HALF_BIT - 32'd1);
  localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(CLKS_PER_BIT - 32'd1);
  localparam logic [2:0]       LAST_IDX     = 3'(DATA_BITS - 32'd1);

  logic       rx_s;
  rx_state_e  state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0] bit_idx_r;
  logic [7:0] shreg_r;
  logic [7:0] rxdata_r;
  logic       valid_r;
  logic       frame_err_r;
  logic       busy_r;

  sync_2ff #(
    .p_WIDTH     (1),
    .p_RESET_VAL (1'b1)
  ) u_sync_rx (
    .clk   (i_clk),
    .rst_n (i_rstn),
    .d     (i_uart_rx),
    .q     (rx_s)
  );

  // Frame FSM: start validation, centre sampling, registered strobes and busy
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_r     <= ST_IDLE;
      cnt_r       <= CNT_ZERO;
      bit_idx_r   <= 3'd0;
      shreg_r     <= 8'h00;
      rxdata_r    <= 8'h00;
      valid_r     <= 1'b0;
      frame_err_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      valid_r     <= 1'b0;
      frame_err_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (!rx_s) begin
            state_r <= ST_START;
            cnt_r   <= CNT_ZERO;
            busy_r  <= 1'b1;
          end
        end
        ST_START: begin
          if (cnt_r == CNT_HALF_END) begin
            cnt_r <= CNT_ZERO;
            if (rx_s) begin
              // Line back high at mid start bit: noise, not a frame
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end else begin
              state_r   <= ST_DATA;
              bit_idx_r <= 3'd0;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_DATA: begin
          if (cnt_r == CNT_BIT_END) begin
            cnt_r              <= CNT_ZERO;
            shreg_r[bit_idx_r] <= rx_s;
            if (bit_idx_r == LAST_IDX) begin
              state_r <= ST_STOP;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_STOP: begin
          if (cnt_r == CNT_BIT_END) begin
            cnt_r <= CNT_ZERO;
            if (rx_s) begin
              rxdata_r <= shreg_r;
              valid_r  <= 1'b1;
              state_r  <= ST_IDLE;
              busy_r   <= 1'b0;
            end else begin
              // Output byte is kept; hold off until the line recovers
              frame_err_r <= 1'b1;
              state_r     <= ST_WAIT_HIGH;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_WAIT_HIGH: begin
          if (rx_s) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= CNT_ZERO;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign o8_rxdata   = rxdata_r;
  assign o_valid     = valid_r;
  assign o_frame_err = frame_err_r;
  assign o_busy      = busy_r;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx. A fast bit rate keeps the run short:
// 12 MHz / 290 kbaud gives round(41.38) = 41 clocks per bit, half bit 20.
// A cycle-level model derived from the frame timing rules predicts every
// output; a byte scoreboard and hand-computed literals pin the model.
module tb_uart_rx;

  localparam int unsigned CLK_FREQ = 12_000_000;
  localparam int unsigned BAUD     = 290_000;
  localparam int C = 41;
  localparam int H = 20;

  logic       clk  = 1'b0;
  logic       rstn = 1'b0;
  logic       pin  = 1'b1;
  logic [7:0] rxdata;
  logic       valid;
  logic       ferr;
  logic       busy;

  uart_rx #(
    .p_BAUDRATE (BAUD),
    .p_CLK_FREQ (CLK_FREQ)
  ) dut (
    .i_clk       (clk),
    .i_rstn      (rstn),
    .i_uart_rx   (pin),
    .o8_rxdata   (rxdata),
    .o_valid     (valid),
    .o_frame_err (ferr),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         cyc       = 0;
  logic       m_s1      = 1'b1;
  logic       m_s2      = 1'b1;
  int         m_mode    = 0;   // 0 idle, 1 inside frame, 2 waiting for line high
  int         m_t0      = 0;
  logic [7:0] m_bits    = 8'h00;
  logic [7:0] exp_data  = 8'h00;
  logic       exp_valid = 1'b0;
  logic       exp_err   = 1'b0;
  logic       exp_busy  = 1'b0;
  int         m_err_cnt = 0;

  initial begin : model
    logic rxs;
    int   d;
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) begin
        m_s1 = 1'b1; m_s2 = 1'b1; m_mode = 0; m_bits = 8'h00;
        exp_data = 8'h00; exp_valid = 1'b0; exp_err = 1'b0; exp_busy = 1'b0;
      end else begin
        cyc++;
        rxs  = m_s2;          // line as seen two clocks after the pin
        m_s2 = m_s1;
        m_s1 = pin;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        case (m_mode)
          0: begin
            if (!rxs) begin
              m_mode = 1; m_t0 = cyc; exp_busy = 1'b1;
            end
          end
          1: begin
            d = cyc - m_t0 - H;
            if (d == 0) begin
              if (rxs) begin
                m_mode = 0; exp_busy = 1'b0;
              end
            end else if (d > 0 && (d % C) == 0) begin
              if (d / C <= 8) begin
                m_bits[3'(d / C - 1)] = rxs;
              end else if (rxs) begin
                exp_data = m_bits; exp_valid = 1'b1; m_mode = 0; exp_busy = 1'b0;
              end else begin
                exp_err = 1'b1; m_err_cnt++; m_mode = 2;
              end
            end
          end
          default: begin
            if (rxs) begin
              m_mode = 0; exp_busy = 1'b0;
            end
          end
        endcase
      end
    end
  end

  // ---------------- compare / monitor ----------------
  logic       chk_en       = 1'b0;
  int         ncyc         = 0;
  int         valid_cnt    = 0;
  int         err_cnt      = 0;
  int         busy_cycles  = 0;
  int         last_valid_t = 0;
  int         prev_valid_t = 0;
  logic [7:0] sb[$];

  initial begin : monitor
    forever begin
      @(negedge clk);
      ncyc++;
      if (chk_en) begin
        check("outputs{data,valid,ferr,busy}", 32'({rxdata, valid, ferr, busy}),
              32'({exp_data, exp_valid, exp_err, exp_busy}));
        if (valid === 1'b1) begin
          valid_cnt++;
          prev_valid_t = last_valid_t;
          last_valid_t = ncyc;
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard: o_valid with data 0x%0h but no byte outstanding", rxdata);
          end else begin
            check("scoreboard_data", 32'(rxdata), 32'(sb.pop_front()));
          end
        end
        if (ferr === 1'b1) err_cnt++;
        if (busy === 1'b1) busy_cycles++;
      end
    end
  end

  // Serial sender; bit period scaled by num/den (num=den=1 is nominal)
  task automatic send_frame(input logic [7:0] data, input logic stop,
                            input int num, input int den, input int nseg);
    logic [9:0] bits;
    int b0, b1;
    bits = {stop, data, 1'b0};
    if (nseg == 10 && stop) sb.push_back(data);
    for (int i = 0; i < nseg; i++) begin
      pin = bits[4'(i)];
      b0 = (i * C * num * 2 + den) / (2 * den);
      b1 = ((i + 1) * C * num * 2 + den) / (2 * den);
      repeat (b1 - b0) @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    pin = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin : stimulus
    repeat (4) @(negedge clk);
    chk_en = 1'b1;
    check("reset_outputs", 32'({rxdata, valid, ferr, busy}), 32'h0);
    @(negedge clk);
    #2 rstn = 1'b1;
    idle(2 * C);

    // Nominal frame 0x21
    busy_cycles = 0;
    send_frame(8'h21, 1'b1, 1, 1, 10);
    idle(2 * C);
    check("frame21_data", 32'(rxdata), 32'h21);
    check("frame21_model_data", 32'(exp_data), 32'h21);
    check("frame21_valid_count", 32'(valid_cnt), 32'd1);
    check("frame21_busy_cycles", 32'(busy_cycles), 32'd389);   // H + 9*C
    check("frame21_no_ferr", 32'(err_cnt), 32'd0);

    // Short low pulse: rejected at mid start bit
    busy_cycles = 0;
    pin = 1'b0;
    repeat (12) @(negedge clk);
    idle(2 * C);
    check("glitch_busy_cycles", 32'(busy_cycles), 32'd20);      // H
    check("glitch_valid_count", 32'(valid_cnt), 32'd1);
    check("glitch_no_ferr", 32'(err_cnt), 32'd0);

    // 0xA5 with low stop bit, line held low three more bit times
    send_frame(8'hA5, 1'b0, 1, 1, 10);
    repeat (3 * C) @(negedge clk);
    check("break_busy_held", 32'(busy), 32'd1);
    check("break_one_ferr", 32'(err_cnt), 32'd1);
    idle(2 * C);
    check("break_one_ferr_after", 32'(err_cnt), 32'd1);
    check("break_model_ferr", 32'(m_err_cnt), 32'd1);
    check("break_data_kept", 32'(rxdata), 32'h21);
    check("break_no_valid", 32'(valid_cnt), 32'd1);
    check("break_busy_low", 32'(busy), 32'd0);

    // Back-to-back frames, zero idle gap
    send_frame(8'h55, 1'b1, 1, 1, 10);
    send_frame(8'hAA, 1'b1, 1, 1, 10);
    idle(2 * C);
    check("b2b_valid_count", 32'(valid_cnt), 32'd3);
    check("b2b_spacing", 32'(last_valid_t - prev_valid_t), 32'd410);   // 10*C
    check("b2b_last_data", 32'(rxdata), 32'hAA);

    // Reset in the middle of the data bits of 0x3C
    send_frame(8'h3C, 1'b1, 1, 1, 5);
    repeat (10) @(negedge clk);
    #2 rstn = 1'b0;
    pin = 1'b1;
    #1 check("midframe_reset_outputs", 32'({rxdata, valid, ferr, busy}), 32'h0);
    repeat (3) @(negedge clk);
    #2 rstn = 1'b1;
    idle(C);
    send_frame(8'h81, 1'b1, 1, 1, 10);
    idle(2 * C);
    check("after_reset_data", 32'(rxdata), 32'h81);
    check("after_reset_valid_count", 32'(valid_cnt), 32'd4);

    // Random bytes with sender +3 % then -3 % off nominal baud
    for (int k = 0; k < 100; k++) begin
      if (k < 50) send_frame(8'($urandom), 1'b1, 100, 103, 10);
      else        send_frame(8'($urandom), 1'b1, 100, 97, 10);
      idle($urandom_range(0, 20));
    end
    idle(2 * C);
    check("tol_valid_count", 32'(valid_cnt), 32'd104);
    check("tol_scoreboard_empty", 32'(sb.size()), 32'd0);
    check("tol_no_new_ferr", 32'(err_cnt), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
